// File: rtl/vmask_pkg.sv
// Shared definitions for the vector compare mask packer: opcodes, SEW codes,
// mask word width and small combinational helpers.
package vmask_pkg;

  typedef enum logic [2:0] {
    CMP_EQ = 3'd0,
    CMP_NE = 3'd1,
    CMP_LT = 3'd2,
    CMP_LE = 3'd3,
    CMP_GT = 3'd4,
    CMP_GE = 3'd5
  } cmp_op_e;

  localparam logic [1:0] SEW_8  = 2'd0;
  localparam logic [1:0] SEW_16 = 2'd1;
  localparam logic [1:0] SEW_32 = 2'd2;
  localparam logic [1:0] SEW_64 = 2'd3;

  localparam int MASK_WORD_W = 64;

  function automatic logic [3:0] elems_per_beat(input logic [1:0] sew);
    return 4'd8 >> sew;
  endfunction

  function automatic logic [6:0] popcount64(input logic [63:0] w);
    logic [6:0] cnt;
    cnt = 7'd0;
    for (int i = 0; i < 64; i++) begin
      cnt = cnt + {6'd0, w[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/v_cmp_lane_compress.sv
// Applies the compare opcode to per-byte-lane flags and reduces them to one
// bit per element, taking the top lane of each SEW-wide element.
module v_cmp_lane_compress
  import vmask_pkg::*;
#(
  parameter int MASK_WIDTH = 8,
  parameter int SEW_WIDTH  = 2,
  parameter int OP_WIDTH   = 3,
  parameter int CNT_WIDTH  = 7
) (
  input  logic [SEW_WIDTH-1:0]  sew,
  input  logic [OP_WIDTH-1:0]   cmp_op,
  input  logic [MASK_WIDTH-1:0] equal,
  input  logic [MASK_WIDTH-1:0] lt,
  input  logic [MASK_WIDTH-1:0] gt,
  output logic [MASK_WIDTH-1:0] elem_o,
  output logic [CNT_WIDTH-1:0]  n_o
);

  logic [MASK_WIDTH-1:0] flag_s;

  // gt already includes equal, so strict GT must mask equal back out
  always_comb begin
    flag_s = '0;
    case (cmp_op)
      OP_WIDTH'(CMP_EQ): flag_s = equal;
      OP_WIDTH'(CMP_NE): flag_s = ~equal;
      OP_WIDTH'(CMP_LT): flag_s = lt;
      OP_WIDTH'(CMP_LE): flag_s = lt | equal;
      OP_WIDTH'(CMP_GT): flag_s = gt & ~equal;
      OP_WIDTH'(CMP_GE): flag_s = gt;
      default:           flag_s = '0;
    endcase
  end

  always_comb begin
    elem_o = '0;
    case (sew)
      SEW_WIDTH'(SEW_8): begin
        for (int k = 0; k < MASK_WIDTH; k++) elem_o[k] = flag_s[k];
      end
      SEW_WIDTH'(SEW_16): begin
        for (int k = 0; k < MASK_WIDTH / 2; k++) elem_o[k] = flag_s[2*k+1];
      end
      SEW_WIDTH'(SEW_32): begin
        for (int k = 0; k < MASK_WIDTH / 4; k++) elem_o[k] = flag_s[4*k+3];
      end
      SEW_WIDTH'(SEW_64): begin
        for (int k = 0; k < MASK_WIDTH / 8; k++) elem_o[k] = flag_s[8*k+7];
      end
      default: elem_o = '0;
    endcase
  end

  assign n_o = CNT_WIDTH'(elems_per_beat(2'(sew)));

endmodule

// File: rtl/v_cmp_mask_packer_chk.sv
// Simulation checker: SEW must not change partway through a mask word.
module v_cmp_mask_packer_chk #(
  parameter int SEW_WIDTH = 2,
  parameter int CNT_WIDTH = 7
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 accept,
  input logic [SEW_WIDTH-1:0] sew,
  input logic [CNT_WIDTH-1:0] ptr
);

  logic [SEW_WIDTH-1:0] last_sew_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_sew_q <= '0;
    end else if (accept) begin
      last_sew_q <= sew;
    end
  end

  sew_stable_a : assert property (@(posedge clk) disable iff (!rst)
    (accept && ptr != '0) |-> (sew == last_sew_q));

endmodule

// File: rtl/v_cmp_mask_packer.sv
// Packs per-element compare results into 64-bit mask words with a
// valid/ready output register. Define VMASK_POPCOUNT_EN to register a popcount.
module v_cmp_mask_packer
  import vmask_pkg::*;
#(
  parameter int MASK_WIDTH = 8,
  parameter int SEW_WIDTH  = 2,
  parameter int OP_WIDTH   = 3,
  parameter int WORD_WIDTH = MASK_WORD_W,
  parameter int CNT_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [SEW_WIDTH-1:0]  sew,
  input  logic [OP_WIDTH-1:0]   cmp_op,
  input  logic [MASK_WIDTH-1:0] equal,
  input  logic [MASK_WIDTH-1:0] lt,
  input  logic [MASK_WIDTH-1:0] gt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_mask,
  output logic [CNT_WIDTH-1:0]  out_bits,
  output logic [CNT_WIDTH-1:0]  out_popc
);

  logic [MASK_WIDTH-1:0] elem_s;
  logic [CNT_WIDTH-1:0]  n_s;
  logic [CNT_WIDTH-1:0]  end_s;
  logic [WORD_WIDTH-1:0] merged_s;
  logic [WORD_WIDTH-1:0] keep_s;
  logic                  accept_s;
  logic                  close_s;

  logic [WORD_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0]  ptr_q, ptr_d;
  logic                  out_valid_q, out_valid_d;
  logic [WORD_WIDTH-1:0] out_mask_q, out_mask_d;
  logic [CNT_WIDTH-1:0]  out_bits_q, out_bits_d;
  logic [CNT_WIDTH-1:0]  out_popc_q, out_popc_d;

  v_cmp_lane_compress #(
    .MASK_WIDTH(MASK_WIDTH),
    .SEW_WIDTH (SEW_WIDTH),
    .OP_WIDTH  (OP_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_compress (
    .sew   (sew),
    .cmp_op(cmp_op),
    .equal (equal),
    .lt    (lt),
    .gt    (gt),
    .elem_o(elem_s),
    .n_o   (n_s)
  );

  assign in_ready = ~out_valid_q | out_ready;
  assign accept_s = in_valid & in_ready;
  assign end_s    = ptr_q + n_s;
  assign close_s  = accept_s & ((end_s == CNT_WIDTH'(WORD_WIDTH)) | in_last);
  assign merged_s = acc_q | (WORD_WIDTH'(elem_s) << ptr_q);

  // keep_s clears every bit at or above the end of the closing word
  always_comb begin
    if (end_s >= CNT_WIDTH'(WORD_WIDTH)) begin
      keep_s = '1;
    end else begin
      keep_s = (WORD_WIDTH'(1) << end_s) - WORD_WIDTH'(1);
    end
  end

  always_comb begin
    acc_d       = acc_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_mask_d  = out_mask_q;
    out_bits_d  = out_bits_q;
    out_popc_d  = out_popc_q;
    if (accept_s) begin
      if (close_s) begin
        acc_d = '0;
        ptr_d = '0;
      end else begin
        acc_d = merged_s;
        ptr_d = end_s;
      end
    end else begin
      acc_d = acc_q;
      ptr_d = ptr_q;
    end
    if (close_s) begin
      out_valid_d = 1'b1;
      out_mask_d  = merged_s & keep_s;
      out_bits_d  = end_s;
`ifdef VMASK_POPCOUNT_EN
      out_popc_d  = CNT_WIDTH'(popcount64(64'(merged_s & keep_s)));
`else
      out_popc_d  = '0;
`endif
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q       <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_mask_q  <= '0;
      out_bits_q  <= '0;
      out_popc_q  <= '0;
    end else begin
      acc_q       <= acc_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_mask_q  <= out_mask_d;
      out_bits_q  <= out_bits_d;
      out_popc_q  <= out_popc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_mask  = out_mask_q;
  assign out_bits  = out_bits_q;
  assign out_popc  = out_popc_q;

  v_cmp_mask_packer_chk #(
    .SEW_WIDTH(SEW_WIDTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) u_chk (
    .clk   (clk),
    .rst   (rst),
    .accept(accept_s),
    .sew   (sew),
    .ptr   (ptr_q)
  );

endmodule
